// File: rtl/and4_seq_pkg.sv
// and4_seq_pkg: shared states, vector constants and reference model for the AND4 sequencer
package and4_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
  localparam int N_VEC = 16;
  localparam int VEC_W = 4;
  function automatic logic expected_y(input logic [VEC_W-1:0] vec);
    return &vec;
  endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: wrapping 0..DWELL-1 counter flagging the last cycle of each dwell window
module dwell_timer #(
  parameter int unsigned DWELL = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == CNT_W'(DWELL - 1);
  always_comb cnt_d = clear ? '0 : !enable ? cnt_q : last ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/and4_vector_sequencer.sv
// and4_vector_sequencer: sweeps all 16 AND4 input vectors, samples y per dwell window, reports mismatches
module and4_vector_sequencer
  import and4_seq_pkg::*;
#(
  parameter int unsigned DWELL = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic [VEC_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_cnt
);
  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [4:0]       err_q, err_d, err_inc;
  logic             pass_q, pass_d;
  logic             last;
  dwell_timer #(.DWELL(DWELL), .CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != DRIVE),
    .enable (state_q == DRIVE),
    .last   (last)
  );
  assign busy         = state_q == DRIVE;
  assign done         = state_q == FINISH;
  assign {a, b, c, d} = busy ? vec_q : '0;
  assign vec_idx      = vec_q;
  assign err_cnt      = err_q;
  assign pass         = pass_q;
  assign err_inc      = err_q + 5'(y != expected_y(vec_q));
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        vec_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
      end
      DRIVE: if (last) begin
        err_d = err_inc;
        if (vec_q == VEC_W'(N_VEC - 1)) begin
          state_d = FINISH;
          pass_d  = err_inc == '0;
        end else vec_d = vec_q + 1'b1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
endmodule

// File: tb/tb_and4_vector_sequencer.sv
// tb_and4_vector_sequencer: directed sweeps against AND, stuck-at-0, OR and inverted-AND gate models
module tb_and4_vector_sequencer;
  typedef struct {
    int   mode;
    int   exp_err;
    logic exp_pass;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  int mode = 0, tests = 0, fails = 0;
  logic a10, b10, c10, d10, busy10, done10, pass10, y10;
  logic a2, b2, c2, d2, busy2, done2, pass2, y2;
  logic [3:0] vi10, vi2, abcd, vi;
  logic [4:0] ec10, ec2, ec;
  logic busy, done, pass;
  always #5 clk = ~clk;
  function automatic logic gate(input int m, input logic [3:0] v);
    return m == 0 ? &v : m == 1 ? 1'b0 : m == 2 ? |v : ~&v;
  endfunction
  assign y10 = gate(mode, {a10, b10, c10, d10});
  assign y2  = gate(mode, {a2, b2, c2, d2});
  and4_vector_sequencer #(.DWELL(10), .CNT_W(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start & !sel), .y(y10),
    .a(a10), .b(b10), .c(c10), .d(d10), .vec_idx(vi10),
    .busy(busy10), .done(done10), .pass(pass10), .err_cnt(ec10)
  );
  and4_vector_sequencer #(.DWELL(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .y(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .vec_idx(vi2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(ec2)
  );
  always_comb begin
    abcd = sel ? {a2, b2, c2, d2} : {a10, b10, c10, d10};
    vi   = sel ? vi2 : vi10;
    ec   = sel ? ec2 : ec10;
    busy = sel ? busy2 : busy10;
    done = sel ? done2 : done10;
    pass = sel ? pass2 : pass10;
  end
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_idle(input string name);
    check({name, "_outs"}, {abcd, vi, busy, done, pass}, 0);
    check({name, "_err"}, ec, 0);
  endtask
  task automatic sweep(input int dw, input int exp_err, input logic exp_pass, input bit pulse, input string name);
    int cyc, busy_n, bad_vec, dones, bad_hold;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    busy_n = 0;
    bad_vec = 0;
    while (!done && cyc < 2000) begin
      if (busy) busy_n++;
      if (!busy || abcd != 4'((cyc - 1) / dw) || vi != abcd) bad_vec++;
      if (pulse) start = (cyc % 7 == 3) && cyc < 16 * dw - 2;
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, cyc, 16 * dw + 1);
    check({name, "_busy_cycles"}, busy_n, 16 * dw);
    check({name, "_bad_vectors"}, bad_vec, 0);
    check({name, "_err_cnt"}, ec, exp_err);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_finish_outs"}, {abcd, busy}, 0);
    dones = 0;
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (busy || pass != exp_pass || ec != 5'(exp_err)) bad_hold++;
    end
    check({name, "_extra_done"}, dones, 0);
    check({name, "_hold"}, bad_hold, 0);
  endtask
  initial begin
    vec_t tbl[4];
    int w, dn;
    tbl[0] = '{0, 0, 1'b1};
    tbl[1] = '{1, 1, 1'b0};
    tbl[2] = '{2, 14, 1'b0};
    tbl[3] = '{3, 16, 1'b0};
    repeat (3) @(posedge clk);
    #1 check_idle("reset10");
    sel = 1'b1;
    #1 check_idle("reset2");
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      sweep(10, tbl[i].exp_err, tbl[i].exp_pass, 1'b0, $sformatf("mode%0d", tbl[i].mode));
    end
    mode = 0;
    sweep(10, 0, 1'b1, 1'b1, "start_pulses");
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w = 0;
    while (vi != 4'd7 && w < 200) begin
      @(posedge clk);
      #1 w++;
    end
    check("reach_vec7", vi, 7);
    rst_n = 1'b0;
    #1 check_idle("abort10");
    dn = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    sel = 1'b1;
    #1 check_idle("abort2");
    @(negedge clk) rst_n = 1'b1;
    sweep(2, 0, 1'b1, 1'b0, "dwell2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
